pe_window_feeder_conv1: RTL and testbench

//  Initiator side of the conv1 PE window interface. Receives the raw input feature map as a raster pixel stream
//  (all pIN_CHANNEL channels per beat) into a circular line buffer. Builds zero-padded KxK windows at stride pSTRIDE.

---
 rtl/pe_conv_pkg.sv | 30 +++
 rtl/pe_window_feeder_conv1_if.sv | 49 ++++
 rtl/pe_line_buffer.sv | 31 +++
 rtl/pe_window_feeder_conv1.sv | 238 +++++++++++++++++++++++
 tb/tb_pe_window_feeder_conv1.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pe_conv_pkg.sv
// Shared types and size helpers for the conv1 window feeder
// and the conv1 MAC controller.
package pe_conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      PRESENT,
      ADVANCE,
      DONE
   } feeder_state_e;

   localparam int DATA_WIDTH = 8;
   localparam int IN_CHANNEL = 3;

   typedef logic [IN_CHANNEL*DATA_WIDTH-1:0] pixel_t;

   function automatic int out_dim(int n, int k, int p, int s);
      return (n - k + 2 * p) / s + 1;
   endfunction

   function automatic int lb_rows(int k, int s);
      return k + s - 1;
   endfunction

   function automatic int cw(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_window_feeder_conv1_if.sv
// Pixel stream and window handshake bundle of the conv1 feeder.
// stall_cycles exists only when PE_FEEDER_STALL_CNT_EN is defined.
interface pe_window_feeder_conv1_if #(
   parameter int PW  = 24,
   parameter int WW  = 216,
   parameter int ORW = 7,
   parameter int OCW = 7
);

   logic           start;
   logic           in_valid;
   logic [PW-1:0]  in_data;
   logic           in_ready;
   logic           en;
   logic           pe_ready;
   logic [WW-1:0]  window_data;
   logic [ORW-1:0] out_row;
   logic [OCW-1:0] out_col;
   logic           busy;
   logic           done;
`ifdef PE_FEEDER_STALL_CNT_EN
   logic [31:0]    stall_cycles;

   modport master (
      input  start, in_valid, in_data, pe_ready,
      output in_ready, en, window_data, out_row, out_col,
      output busy, done, stall_cycles
   );

   modport slave (
      output start, in_valid, in_data, pe_ready,
      input  in_ready, en, window_data, out_row, out_col,
      input  busy, done, stall_cycles
   );
`else
   modport master (
      input  start, in_valid, in_data, pe_ready,
      output in_ready, en, window_data, out_row, out_col,
      output busy, done
   );

   modport slave (
      output start, in_valid, in_data, pe_ready,
      input  in_ready, en, window_data, out_row, out_col,
      input  busy, done
   );
`endif

endinterface

// File: rtl/pe_line_buffer.sv
// Circular row buffer: one write port, one read port,
// registered read data (1-cycle latency).
module pe_line_buffer
   import pe_conv_pkg::*;
#(
   parameter int  pROWS  = 4,
   parameter int  pWIDTH = 224,
   parameter type pix_t  = pixel_t,
   localparam int SW = cw(pROWS),
   localparam int CW = cw(pWIDTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [SW-1:0] wr_slot,
   input  logic [CW-1:0] wr_col,
   input  pix_t          wr_data,
   input  logic [SW-1:0] rd_slot,
   input  logic [CW-1:0] rd_col,
   output pix_t          rd_data
);

   pix_t mem [pROWS][pWIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_slot][wr_col] <= wr_data;
      end
      rd_data <= mem[rd_slot][rd_col];
   end

endmodule

// File: rtl/pe_window_feeder_conv1.sv
// conv1 window feeder: raster pixels in, zero-padded KxK windows out.
// Define PE_FEEDER_STALL_CNT_EN to add the stall_cycles counter.
module pe_window_feeder_conv1
   import pe_conv_pkg::*;
#(
   parameter int pDATA_WIDTH   = 8,
   parameter int pIN_CHANNEL   = 3,
   parameter int pKERNEL_SIZE  = 3,
   parameter int pINPUT_WIDTH  = 224,
   parameter int pINPUT_HEIGHT = 224,
   parameter int pPADDING      = 1,
   parameter int pSTRIDE       = 2,
   parameter int pPAD_VALUE    = 0
) (
   input logic clk,
   input logic rst_n,
   pe_window_feeder_conv1_if.master bus
);

   localparam int W   = pINPUT_WIDTH;
   localparam int H   = pINPUT_HEIGHT;
   localparam int K   = pKERNEL_SIZE;
   localparam int S   = pSTRIDE;
   localparam int P   = pPADDING;
   localparam int OW  = out_dim(W, K, P, S);
   localparam int OH  = out_dim(H, K, P, S);
   localparam int LB  = lb_rows(K, S);
   localparam int KK  = K * K;
   localparam int PW  = pIN_CHANNEL * pDATA_WIDTH;
   localparam int RW  = cw(H + 1);
   localparam int CW  = cw(W);
   localparam int ORW = cw(OH);
   localparam int OCW = cw(OW);
   localparam int SW  = cw(LB);
   localparam int KW  = cw(K + 1);
   localparam int TW  = cw(KK);

   localparam logic [PW-1:0] PAD =
      {pIN_CHANNEL{pDATA_WIDTH'(pPAD_VALUE)}};

   feeder_state_e  state;
   logic [RW-1:0]  in_row;
   logic [CW-1:0]  in_col;
   logic [ORW-1:0] out_row;
   logic [OCW-1:0] out_col;
   logic [KW-1:0]  ky;
   logic [KW-1:0]  kx;
   logic           rd_act;
   logic           cap_vld;
   logic           cap_pad;
   logic [TW-1:0]  cap_idx;
   logic           en;
   logic           busy;
   logic           done;
   logic [PW-1:0]  win [KK];
   logic [PW-1:0]  rd_data;

   int   top_row;
   int   bot_row;
   int   lim_row;
   int   tap_row;
   int   tap_col;
   logic rows_ready;
   logic tap_pad;
   logic in_ready;
   logic accept;
   logic [SW-1:0] rd_slot;
   logic [CW-1:0] rd_col;
   logic [SW-1:0] wr_slot;

   always_comb begin
      top_row    = int'(out_row) * S - P;
      bot_row    = (top_row + K - 1 < H - 1) ? top_row + K - 1 : H - 1;
      lim_row    = ((top_row > 0) ? top_row : 0) + LB;
      rows_ready = int'(in_row) > bot_row;
      in_ready   = busy && int'(in_row) < H && int'(in_row) < lim_row;
      accept     = bus.in_valid && in_ready;
      tap_row    = top_row + int'(ky);
      tap_col    = int'(out_col) * S - P + int'(kx);
      tap_pad    = tap_row < 0 || tap_row >= H ||
                   tap_col < 0 || tap_col >= W;
      // padded taps never touch the buffer, so park the address
      rd_slot    = tap_pad ? '0 : SW'(tap_row % LB);
      rd_col     = tap_pad ? '0 : CW'(tap_col);
      wr_slot    = SW'(int'(in_row) % LB);
   end

   pe_line_buffer #(
      .pROWS  (LB),
      .pWIDTH (W),
      .pix_t  (logic [PW-1:0])
   ) u_lb (
      .clk     (clk),
      .wr_en   (accept),
      .wr_slot (wr_slot),
      .wr_col  (in_col),
      .wr_data (bus.in_data),
      .rd_slot (rd_slot),
      .rd_col  (rd_col),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         in_row  <= '0;
         in_col  <= '0;
         out_row <= '0;
         out_col <= '0;
         ky      <= '0;
         kx      <= '0;
         rd_act  <= 1'b0;
         cap_vld <= 1'b0;
         cap_pad <= 1'b0;
         cap_idx <= '0;
         en      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         for (int t = 0; t < KK; t++) begin
            win[t] <= '0;
         end
      end else begin
         done    <= 1'b0;
         cap_vld <= 1'b0;
         if (accept) begin
            if (int'(in_col) == W - 1) begin
               in_col <= '0;
               in_row <= in_row + RW'(1);
            end else begin
               in_col <= in_col + CW'(1);
            end
         end
         if (cap_vld) begin
            win[cap_idx] <= cap_pad ? PAD : rd_data;
         end
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state   <= FILL;
                  busy    <= 1'b1;
                  in_row  <= '0;
                  in_col  <= '0;
                  out_row <= '0;
                  out_col <= '0;
                  rd_act  <= 1'b0;
               end
            end
            FILL: begin
               if (!rd_act) begin
                  if (rows_ready) begin
                     rd_act <= 1'b1;
                     ky     <= '0;
                     kx     <= '0;
                  end
               end else begin
                  // ky == K marks every tap issued; wait for the last capture
                  if (int'(ky) < K) begin
                     cap_vld <= 1'b1;
                     cap_pad <= tap_pad;
                     cap_idx <= TW'(int'(ky) * K + int'(kx));
                     if (int'(kx) == K - 1) begin
                        kx <= '0;
                        ky <= ky + KW'(1);
                     end else begin
                        kx <= kx + KW'(1);
                     end
                  end
                  if (cap_vld && int'(cap_idx) == KK - 1) begin
                     rd_act <= 1'b0;
                     en     <= 1'b1;
                     state  <= PRESENT;
                  end
               end
            end
            PRESENT: begin
               if (bus.pe_ready) begin
                  en    <= 1'b0;
                  state <= ADVANCE;
               end
            end
            ADVANCE: begin
               if (int'(out_col) == OW - 1) begin
                  out_col <= '0;
                  if (int'(out_row) == OH - 1) begin
                     out_row <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state   <= DONE;
                  end else begin
                     out_row <= out_row + ORW'(1);
                     state   <= FILL;
                  end
               end else begin
                  out_col <= out_col + OCW'(1);
                  state   <= FILL;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.window_data = '0;
      for (int t = 0; t < KK; t++) begin
         bus.window_data[t*PW +: PW] = win[t];
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.en       = en;
   assign bus.out_row  = out_row;
   assign bus.out_col  = out_col;
   assign bus.busy     = busy;
   assign bus.done     = done;

`ifdef PE_FEEDER_STALL_CNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (state == IDLE && bus.start) begin
         stall_cnt <= '0;
      end else if (en && !bus.pe_ready && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_pe_window_feeder_conv1.sv
// Self-checking bench for pe_window_feeder_conv1 (W=H=5, K=3, P=1, S=2, C=1).
// Expected windows come from a padded-image model of the frame.
module tb_pe_window_feeder_conv1;

   localparam int W  = 5;
   localparam int H  = 5;
   localparam int K  = 3;
   localparam int P  = 1;
   localparam int S  = 2;
   localparam int OW = 3;
   localparam int OH = 3;
   localparam int NW = OW * OH;
   localparam int NB = W * H;

   typedef struct {
      int          r;
      int          c;
      logic [71:0] taps;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic [7:0]  img [NB];
   logic [71:0] got [NW];
   vec_t        tbl [5];

   always #5 clk = ~clk;

   pe_window_feeder_conv1_if #(
      .PW(8), .WW(72), .ORW(2), .OCW(2)
   ) bus ();

   pe_window_feeder_conv1 #(
      .pDATA_WIDTH   (8),
      .pIN_CHANNEL   (1),
      .pKERNEL_SIZE  (K),
      .pINPUT_WIDTH  (W),
      .pINPUT_HEIGHT (H),
      .pPADDING      (P),
      .pSTRIDE       (S),
      .pPAD_VALUE    (0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [71:0] act,
                      input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [71:0] pk(input int a0, input int a1,
      input int a2, input int a3, input int a4, input int a5,
      input int a6, input int a7, input int a8);
      logic [71:0] v;
      v = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4),
           8'(a3), 8'(a2), 8'(a1), 8'(a0)};
      return v;
   endfunction

   // padded-image reference: tap (ky,kx) = image(orow*S-P+ky, ocol*S-P+kx)
   function automatic logic [71:0] exp_win(input int orow, input int ocol);
      logic [71:0] v;
      int r;
      int c;
      v = '0;
      for (int ky = 0; ky < K; ky++) begin
         for (int kx = 0; kx < K; kx++) begin
            r = orow * S - P + ky;
            c = ocol * S - P + kx;
            if (r >= 0 && r < H && c >= 0 && c < W) begin
               v[(ky * K + kx) * 8 +: 8] = img[r * W + c];
            end
         end
      end
      return v;
   endfunction

   task automatic chk_rst(input string tag);
      chk($sformatf("%s_en", tag), 72'(bus.en), 0);
      chk($sformatf("%s_busy", tag), 72'(bus.busy), 0);
      chk($sformatf("%s_done", tag), 72'(bus.done), 0);
      chk($sformatf("%s_in_ready", tag), 72'(bus.in_ready), 0);
      chk($sformatf("%s_out_row", tag), 72'(bus.out_row), 0);
      chk($sformatf("%s_out_col", tag), 72'(bus.out_col), 0);
      chk($sformatf("%s_window", tag), bus.window_data, 0);
   endtask

   // vmode: 0 always valid, 1 toggle, 2 random; rmode: 0 ready, 2 random
   task automatic run_frame(input string tag, input int vmode,
      input int rmode, input int stall_k, input int abort_k,
      input int start_k, output int done_cyc);
      int beats;
      int k;
      int ndone;
      int cyc;
      int hold;
      bit v;
      bit rdy;
      bit poked;
      logic [7:0]  dat;
      logic [71:0] held;
      beats = 0; k = 0; ndone = 0; cyc = 0; hold = 0;
      poked = 1'b0; held = '0; done_cyc = -1;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < 3000 && !(ndone > 0 && cyc >= done_cyc + 3)) begin
         if (abort_k >= 0 && k == abort_k && bus.en) begin
            rst_n = 1'b0;
            bus.in_valid = 1'b0;
            bus.pe_ready = 1'b0;
            #1;
            chk_rst($sformatf("%s_abort", tag));
            chk($sformatf("%s_abort_no_done", tag), 72'(ndone), 0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (bus.done) begin
            ndone++;
            done_cyc = cyc;
         end
         if (vmode == 0) v = 1'b1;
         else if (vmode == 1) v = (cyc % 2) == 0;
         else v = 1'($urandom_range(0, 1));
         rdy = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (stall_k >= 0 && k == stall_k && bus.en && hold < 20) begin
            rdy = 1'b0;
            if (hold == 0) held = bus.window_data;
            else chk($sformatf("%s_hold", tag), bus.window_data, held);
            if (hold == 19) begin
               chk($sformatf("%s_full_in_ready", tag), 72'(bus.in_ready), 0);
               chk($sformatf("%s_full_beats", tag), 72'(beats), 20);
            end
            hold++;
         end
         if (start_k >= 0 && k == start_k && bus.en && !poked) begin
            bus.start = 1'b1;
            poked = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.en && rdy) begin
            if (k < NW) begin
               chk($sformatf("%s_win%0d", tag, k), bus.window_data,
                   exp_win(k / OW, k % OW));
               chk($sformatf("%s_row%0d", tag, k), 72'(bus.out_row),
                   72'(k / OW));
               chk($sformatf("%s_col%0d", tag, k), 72'(bus.out_col),
                   72'(k % OW));
               got[k] = bus.window_data;
            end
            k++;
         end
         dat = (beats < NB) ? img[beats] : 8'hEE;
         if (v && bus.in_ready) beats++;
         bus.in_valid = v;
         bus.in_data = dat;
         bus.pe_ready = rdy;
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("%s_windows", tag), 72'(k), NW);
      chk($sformatf("%s_beats", tag), 72'(beats), NB);
      chk($sformatf("%s_done_count", tag), 72'(ndone), 1);
      chk($sformatf("%s_busy_end", tag), 72'(bus.busy), 0);
      if (stall_k >= 0) chk($sformatf("%s_hold_len", tag), 72'(hold), 20);
      bus.in_valid = 1'b0;
      bus.pe_ready = 1'b0;
      bus.start = 1'b0;
   endtask

   initial begin
      int d1;
      int dx;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.pe_ready = 1'b0;
      tbl[0] = '{0, 0, pk(0, 0, 0, 0, 1, 2, 0, 6, 7)};
      tbl[1] = '{0, 1, pk(0, 0, 0, 2, 3, 4, 7, 8, 9)};
      tbl[2] = '{1, 1, pk(7, 8, 9, 12, 13, 14, 17, 18, 19)};
      tbl[3] = '{2, 0, pk(0, 16, 17, 0, 21, 22, 0, 0, 0)};
      tbl[4] = '{2, 2, pk(19, 20, 0, 24, 25, 0, 0, 0, 0)};
      for (int i = 0; i < NB; i++) img[i] = 8'(i + 1);

      repeat (3) @(negedge clk);
      chk_rst("reset");
      rst_n = 1'b1;

      run_frame("s1", 0, 0, -1, -1, -1, d1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("tbl_%0d_%0d", tbl[i].r, tbl[i].c),
             got[tbl[i].r * OW + tbl[i].c], tbl[i].taps);
      end
`ifdef PE_FEEDER_STALL_CNT_EN
      chk("s1_stall_cycles", 72'(bus.stall_cycles), 0);
`endif

      run_frame("s3", 0, 0, 1, -1, -1, dx);
`ifdef PE_FEEDER_STALL_CNT_EN
      chk("s3_stall_cycles", 72'(bus.stall_cycles), 20);
`endif

      run_frame("s4", 1, 0, -1, -1, -1, dx);

      run_frame("s5a", 0, 0, -1, 3, -1, dx);
      run_frame("s5b", 0, 0, -1, -1, -1, dx);

      run_frame("s6", 0, 0, -1, -1, 4, dx);
      chk("s6_done_time", 72'(dx), 72'(d1));

      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NB; i++) img[i] = 8'($urandom_range(0, 255));
         run_frame($sformatf("rnd%0d", f), 2, 2, -1, -1, -1, dx);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
